rng_dist_fifo: RTL and testbench

//  Parametrised successor of the TRNG-to-sampler distribution buffer. Parses framed random

---
 rtl/rng_dist_fifo.sv | 138 +++++++++++++
 tb/tb_rng_dist_fifo.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_dist_fifo.sv
// TRNG-to-sampler distribution buffer: parses framed TRNG words and deals each
// payload into one of NCH show-ahead channel FIFOs with round-robin or most-starved fill.
module rng_dist_fifo #(
    parameter int unsigned NCH       = 8,
    parameter int unsigned DW        = 32,
    parameter int unsigned DEPTH     = 8,
    parameter bit          HDR_EN    = 1'b1,
    parameter logic [31:0] SYNC0     = 32'h00000071,
    parameter logic [31:0] SYNC1     = 32'h0280f76b,
    parameter bit          FILL_MODE = 1'b0,
    localparam int unsigned LW       = $clog2(DEPTH + 1)
) (
    input  logic              clk_sample,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DW-1:0]     in_data,
    output logic              in_ready,
    input  logic [NCH-1:0]    out_rd,
    output logic [NCH-1:0]    out_valid,
    output logic [NCH*DW-1:0] out_data,
    output logic [NCH*LW-1:0] out_level,
    output logic [NCH-1:0]    rd_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    localparam logic [DW-1:0] S0 = DW'(SYNC0);
    localparam logic [DW-1:0] S1 = DW'(SYNC1);

    typedef enum logic [1:0] {HUNT0, HUNT1, PAYLOAD} state_t;
    localparam state_t RST_STATE = HDR_EN ? HUNT0 : PAYLOAD;

    state_t state, state_nxt;

    logic [DW-1:0] mem    [NCH][DEPTH];
    logic [AW-1:0] wr_ptr [NCH];
    logic [AW-1:0] rd_ptr [NCH];
    logic [LW-1:0] level  [NCH];
    logic [CW-1:0] rr;

    logic [CW-1:0]  target;
    logic [CW-1:0]  idx_c;
    logic [LW-1:0]  best;
    logic           any_space;
    logic           accept;
    logic           wr_en;
    logic [NCH-1:0] wr_vec;
    logic [NCH-1:0] pop_vec;

    // Target choice uses only registered levels, so a same-cycle pop never frees a full channel.
    always_comb begin
        target    = '0;
        idx_c     = '0;
        best      = FULL;
        any_space = 1'b0;
        if (!FILL_MODE) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                idx_c = CW'((32'(rr) + k) % NCH);
                if (!any_space && level[idx_c] != FULL) begin
                    any_space = 1'b1;
                    target    = idx_c;
                end
            end
        end else begin
            for (int unsigned c = 0; c < NCH; c++) begin
                if (level[CW'(c)] < best) begin
                    best      = level[CW'(c)];
                    target    = CW'(c);
                    any_space = 1'b1;
                end
            end
        end
    end

    always_comb begin
        in_ready  = !rst && ((state != PAYLOAD) || any_space);
        accept    = in_valid && in_ready;
        wr_en     = accept && (state == PAYLOAD);
        state_nxt = state;
        if (!HDR_EN) begin
            state_nxt = PAYLOAD;
        end else if (accept) begin
            case (state)
                HUNT0:   if (in_data == S0) state_nxt = HUNT1;
                HUNT1:   if (in_data == S1) state_nxt = PAYLOAD;
                default: state_nxt = HUNT0;
            endcase
        end
        for (int unsigned c = 0; c < NCH; c++) begin
            wr_vec[c]  = wr_en && (target == CW'(c));
            pop_vec[c] = out_rd[c] && (level[CW'(c)] != '0);
        end
    end

    always_ff @(posedge clk_sample) begin
        if (rst) state <= RST_STATE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk_sample) begin
        for (int unsigned c = 0; c < NCH; c++) begin
            if (wr_vec[c]) mem[CW'(c)][wr_ptr[CW'(c)]] <= in_data;
        end
    end

    always_ff @(posedge clk_sample) begin
        if (rst) begin
            rr     <= '0;
            rd_err <= '0;
            for (int unsigned c = 0; c < NCH; c++) begin
                wr_ptr[CW'(c)] <= '0;
                rd_ptr[CW'(c)] <= '0;
                level[CW'(c)]  <= '0;
            end
        end else begin
            if (wr_en) rr <= (target == CW'(NCH - 1)) ? '0 : target + 1'b1;
            for (int unsigned c = 0; c < NCH; c++) begin
                if (wr_vec[c])  wr_ptr[CW'(c)] <= wr_ptr[CW'(c)] + 1'b1;
                if (pop_vec[c]) rd_ptr[CW'(c)] <= rd_ptr[CW'(c)] + 1'b1;
                if (out_rd[c] && level[CW'(c)] == '0) rd_err[c] <= 1'b1;
                level[CW'(c)] <= level[CW'(c)] + LW'(wr_vec[c]) - LW'(pop_vec[c]);
            end
        end
    end

    always_comb begin
        out_valid = '0;
        out_data  = '0;
        out_level = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            out_valid[c]           = (level[CW'(c)] != '0);
            out_data[c*DW +: DW]   = mem[CW'(c)][rd_ptr[CW'(c)]];
            out_level[c*LW +: LW]  = level[CW'(c)];
        end
    end

endmodule

// File: tb/tb_rng_dist_fifo.sv
// Bench for rng_dist_fifo: three configurations (framed RR, raw RR, raw min-first)
// checked against queue-based models under directed and randomized traffic.
module tb_rng_dist_fifo;

    localparam int NCH   = 8;
    localparam int DEPTH = 8;
    localparam logic [31:0] S0 = 32'h00000071;
    localparam logic [31:0] S1 = 32'h0280f76b;

    logic clk_sample = 1'b0;
    logic rst = 1'b1;
    always #5 clk_sample = ~clk_sample;

    logic         iv [3];
    logic [31:0]  id [3];
    logic [7:0]   rd [3];
    logic         ir [3];
    logic [7:0]   ov [3];
    logic [255:0] od [3];
    logic [31:0]  ol [3];
    logic [7:0]   re [3];

    rng_dist_fifo #(.NCH(8), .DW(32), .DEPTH(8), .HDR_EN(1'b1), .SYNC0(S0), .SYNC1(S1), .FILL_MODE(1'b0)) dut_a (
        .clk_sample(clk_sample), .rst(rst), .in_valid(iv[0]), .in_data(id[0]), .in_ready(ir[0]),
        .out_rd(rd[0]), .out_valid(ov[0]), .out_data(od[0]), .out_level(ol[0]), .rd_err(re[0]));
    rng_dist_fifo #(.NCH(8), .DW(32), .DEPTH(8), .HDR_EN(1'b0), .SYNC0(S0), .SYNC1(S1), .FILL_MODE(1'b0)) dut_b (
        .clk_sample(clk_sample), .rst(rst), .in_valid(iv[1]), .in_data(id[1]), .in_ready(ir[1]),
        .out_rd(rd[1]), .out_valid(ov[1]), .out_data(od[1]), .out_level(ol[1]), .rd_err(re[1]));
    rng_dist_fifo #(.NCH(8), .DW(32), .DEPTH(8), .HDR_EN(1'b0), .SYNC0(S0), .SYNC1(S1), .FILL_MODE(1'b1)) dut_c (
        .clk_sample(clk_sample), .rst(rst), .in_valid(iv[2]), .in_data(id[2]), .in_ready(ir[2]),
        .out_rd(rd[2]), .out_valid(ov[2]), .out_data(od[2]), .out_level(ol[2]), .rd_err(re[2]));

    // Reference model: one queue per channel, parser progress as 0/1/2 = sync0/sync1/payload.
    bit          hdr [3] = '{1'b1, 1'b0, 1'b0};
    bit          fm  [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] mq  [3][8][$];
    int          ps  [3];
    int          rrp [3];
    logic [7:0]  merr[3];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_ready(int d);
        if (ps[d] != 2) return 1'b1;
        for (int c = 0; c < NCH; c++) if (mq[d][c].size() < DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_pick(int d);
        int best_c;
        int best_l;
        best_c = -1;
        best_l = DEPTH;
        if (fm[d]) begin
            for (int c = 0; c < NCH; c++)
                if (mq[d][c].size() < best_l) begin
                    best_l = mq[d][c].size();
                    best_c = c;
                end
        end else begin
            for (int k = 0; k < NCH; k++)
                if (best_c < 0 && mq[d][(rrp[d] + k) % NCH].size() < DEPTH) best_c = (rrp[d] + k) % NCH;
        end
        return best_c;
    endfunction

    task automatic m_step(int d);
        bit acc;
        int tgt;
        acc = iv[d] && m_ready(d);
        tgt = (acc && ps[d] == 2) ? m_pick(d) : -1;
        for (int c = 0; c < NCH; c++)
            if (rd[d][c]) begin
                if (mq[d][c].size() > 0) void'(mq[d][c].pop_front());
                else merr[d][c] = 1'b1;
            end
        if (acc) begin
            case (ps[d])
                0: if (id[d] == S0) ps[d] = 1;
                1: if (id[d] == S1) ps[d] = 2;
                default: begin
                    mq[d][tgt].push_back(id[d]);
                    rrp[d] = (tgt + 1) % NCH;
                    if (hdr[d]) ps[d] = 0;
                end
            endcase
        end
    endtask

    task automatic m_reset();
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < NCH; c++) mq[d][c].delete();
            ps[d]   = hdr[d] ? 0 : 2;
            rrp[d]  = 0;
            merr[d] = '0;
        end
    endtask

    task automatic check_outputs(int d);
        logic [7:0]   ev;
        logic [31:0]  el;
        logic [255:0] ed;
        logic [255:0] mask;
        ev = '0; el = '0; ed = '0; mask = '0;
        for (int c = 0; c < NCH; c++) begin
            el[c*4 +: 4] = 4'(mq[d][c].size());
            if (mq[d][c].size() > 0) begin
                ev[c] = 1'b1;
                ed[c*32 +: 32] = mq[d][c][0];
                mask[c*32 +: 32] = '1;
            end
        end
        chk($sformatf("valid%0d", d), 256'(ov[d]), 256'(ev));
        chk($sformatf("level%0d", d), 256'(ol[d]), 256'(el));
        chk($sformatf("rderr%0d", d), 256'(re[d]), 256'(merr[d]));
        chk($sformatf("data%0d", d), od[d] & mask, ed);
    endtask

    task automatic idle();
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0;
            id[d] = '0;
            rd[d] = '0;
        end
    endtask

    task automatic step();
        #1;
        for (int d = 0; d < 3; d++) chk($sformatf("ready%0d", d), 256'(ir[d]), 256'(m_ready(d)));
        @(posedge clk_sample);
        #1;
        for (int d = 0; d < 3; d++) m_step(d);
        for (int d = 0; d < 3; d++) check_outputs(d);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk_sample);
        #1;
        m_reset();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("ready_in_rst%0d", d), 256'(ir[d]), 256'(0));
            check_outputs(d);
        end
        rst = 1'b0;
    endtask

    task automatic send(int d, logic [31:0] w);
        idle();
        iv[d] = 1'b1;
        id[d] = w;
        step();
        idle();
    endtask

    initial begin
        idle();
        m_reset();

        // T1: two frames land in ch0 then ch1
        do_reset();
        send(0, S0); send(0, S1); send(0, 32'hDEADBEEF);
        chk("t1_valid0", 256'(ov[0][0]), 256'(1));
        chk("t1_data0", 256'(od[0][31:0]), 256'(32'hDEADBEEF));
        chk("t1_level0", 256'(ol[0][3:0]), 256'(1));
        send(0, S0); send(0, S1); send(0, 32'hCAFEF00D);
        chk("t1_data1", 256'(od[0][63:32]), 256'(32'hCAFEF00D));

        // T2: bad SYNC1 discarded, parser keeps hunting for SYNC1
        do_reset();
        send(0, S0); send(0, 32'h12345678); send(0, S1); send(0, 32'h000000A5);
        chk("t2_data0", 256'(od[0][31:0]), 256'(32'hA5));
        chk("t2_levels", 256'(ol[0]), 256'(32'h1));

        // T3: raw mode fills everything, one pop frees exactly one slot
        do_reset();
        for (int w = 0; w < 64; w++) send(1, 32'(w));
        chk("t3_levels_full", 256'(ol[1]), 256'(32'h88888888));
        chk("t3_ready_full", 256'(ir[1]), 256'(0));
        chk("t3_head3", 256'(od[1][3*32 +: 32]), 256'(3));
        iv[1] = 1'b1; id[1] = 32'd64; rd[1] = 8'h08;
        step();
        rd[1] = 8'h00;
        step();
        idle();
        chk("t3_levels_refill", 256'(ol[1]), 256'(32'h88888888));
        chk("t3_ready_after", 256'(ir[1]), 256'(0));
        chk("t3_head3_after", 256'(od[1][3*32 +: 32]), 256'(11));

        // T4: min-first picks the starved channel
        do_reset();
        for (int w = 0; w < 17; w++) send(2, $urandom);
        rd[2] = 8'h20;
        step(); step();
        idle();
        chk("t4_levels", 256'(ol[2]), 256'(32'h22022223));
        send(2, 32'h00005A5A);
        chk("t4_pick5", 256'(ol[2]), 256'(32'h22122223));
        chk("t4_data5", 256'(od[2][5*32 +: 32]), 256'(32'h00005A5A));

        // T5: tie goes to ch0; write+pop at level 1; sticky read error
        do_reset();
        send(2, 32'h1111);
        chk("t5_tie_ch0", 256'(ol[2]), 256'(32'h1));
        for (int w = 0; w < 10; w++) send(1, 32'(100 + w));
        iv[1] = 1'b1; id[1] = 32'h55; rd[1] = 8'h04;
        step();
        idle();
        chk("t5_head2", 256'(od[1][2*32 +: 32]), 256'(32'h55));
        chk("t5_level2", 256'(ol[1][11:8]), 256'(1));
        rd[0] = 8'h10;
        step();
        idle();
        chk("t5_rderr4", 256'(re[0][4]), 256'(1));
        chk("t5_level4", 256'(ol[0][19:16]), 256'(0));
        step(); step();
        chk("t5_rderr4_sticky", 256'(re[0][4]), 256'(1));
        do_reset();
        chk("t5_rderr_clear", 256'(re[0]), 256'(0));

        // T6: reset mid-frame drops the partial header
        send(0, S0); send(0, S1);
        do_reset();
        send(0, 32'h99);
        chk("t6_levels", 256'(ol[0]), 256'(0));
        chk("t6_valid", 256'(ov[0]), 256'(0));

        // Randomized traffic with alternating pop intensity
        do_reset();
        for (int i = 0; i < 1200; i++) begin
            for (int d = 0; d < 3; d++) begin
                int r;
                iv[d] = ($urandom_range(0, 3) != 0);
                r = $urandom_range(0, 9);
                if (d == 0 && r < 3) id[d] = S0;
                else if (d == 0 && r < 6) id[d] = S1;
                else id[d] = $urandom;
                if ((i / 150) % 2 == 1) rd[d] = 8'($urandom) & 8'($urandom);
                else rd[d] = 8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom);
            end
            step();
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
